// File: rtl/alu_op_sequencer.sv
// Multi-cycle controller for the shared 16-bit add/sub ALU: sequences ADD, SUB, CMP
// and an iterative shift-add MUL, then returns the result and ALU flags over valid/ready.
module alu_op_sequencer #(
    parameter int WIDTH    = 16,
    parameter int MUL_BITS = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic [3:0]       rsp_flags,
    output logic             busy,
    output logic [WIDTH-1:0] alu_in1,
    output logic [WIDTH-1:0] alu_in2,
    output logic             alu_sub_en,
    output logic             alu_status_out_en,
    input  logic [WIDTH-1:0] alu_out
);

    localparam int CNT_W = $clog2(MUL_BITS + 1);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_CMP = 2'b11;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both
    // high; a producer holds valid and its payload stable until that edge.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_EXEC = 3'd1,
        S_MUL  = 3'd2,
        S_FLAG = 3'd3,
        S_RESP = 3'd4
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [1:0]        op;
    logic [WIDTH-1:0]  op_a;
    logic [WIDTH-1:0]  op_b;
    logic [WIDTH-1:0]  acc;
    logic [WIDTH-1:0]  mcand;
    logic [WIDTH-1:0]  mplier;
    logic [WIDTH-1:0]  res;
    logic [CNT_W-1:0]  count;
    logic              accept;
    logic              mul_last;

    assign accept   = req_valid && (state == S_IDLE);
    assign mul_last = (count == CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = (req_op == OP_MUL) ? S_MUL : S_EXEC;
                end
            end
            S_EXEC: state_nxt = S_FLAG;
            S_MUL: begin
                if (mul_last) begin
                    state_nxt = S_FLAG;
                end
            end
            S_FLAG: state_nxt = S_RESP;
            S_RESP: begin
                if (rsp_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready         = (state == S_IDLE);
        busy              = (state != S_IDLE);
        rsp_valid         = (state == S_RESP);
        alu_in1           = '0;
        alu_in2           = '0;
        alu_sub_en        = 1'b0;
        alu_status_out_en = 1'b0;
        case (state)
            S_EXEC: begin
                alu_in1    = op_a;
                alu_in2    = op_b;
                alu_sub_en = (op != OP_ADD);
            end
            S_MUL: begin
                alu_in1 = acc;
                alu_in2 = mcand;
            end
            S_FLAG: begin
                alu_status_out_en = 1'b1;
                // MUL flags describe the product itself, read back as res + 0.
                if (op == OP_MUL) begin
                    alu_in1 = res;
                end else begin
                    alu_in1    = op_a;
                    alu_in2    = op_b;
                    alu_sub_en = (op != OP_ADD);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op        <= '0;
            op_a      <= '0;
            op_b      <= '0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            count     <= '0;
            res       <= '0;
            rsp_data  <= '0;
            rsp_flags <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op     <= req_op;
                        op_a   <= req_a;
                        op_b   <= req_b;
                        acc    <= '0;
                        mcand  <= req_a;
                        mplier <= req_b;
                        count  <= CNT_W'(MUL_BITS);
                    end
                end
                S_EXEC: begin
                    res <= (op == OP_CMP) ? '0 : alu_out;
                end
                S_MUL: begin
                    // Fixed iteration count: every multiplier bit is examined, no early exit.
                    if (mplier[0]) begin
                        acc <= alu_out;
                    end
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count - CNT_W'(1);
                    if (mul_last) begin
                        res <= mplier[0] ? alu_out : acc;
                    end
                end
                S_FLAG: begin
                    rsp_flags <= alu_out[3:0];
                    rsp_data  <= res;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: behavioural ALU model on the drive pins, scoreboarded
// responses, latency, backpressure and mid-operation reset scenarios.
module tb_alu_op_sequencer;

    localparam int WIDTH    = 16;
    localparam int MUL_BITS = 16;
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_CMP = 2'b11;

    logic             clk;
    logic             rst_n;
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_op;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic [3:0]       rsp_flags;
    logic             busy;
    logic [WIDTH-1:0] alu_in1;
    logic [WIDTH-1:0] alu_in2;
    logic             alu_sub_en;
    logic             alu_status_out_en;
    logic [WIDTH-1:0] alu_out;

    int checks   = 0;
    int failures = 0;
    logic [WIDTH+3:0] exp_q[$];

    alu_op_sequencer #(.WIDTH(WIDTH), .MUL_BITS(MUL_BITS)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_flags(rsp_flags), .busy(busy),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_sub_en(alu_sub_en),
        .alu_status_out_en(alu_status_out_en), .alu_out(alu_out)
    );

    // ALU model: flags come from the 17-bit result {parity, carry, ones, zero}.
    function automatic logic [16:0] alu_sum(input logic [15:0] x, input logic [15:0] y, input logic sub);
        return sub ? ({1'b0, x} - {1'b0, y}) : ({1'b0, x} + {1'b0, y});
    endfunction

    function automatic logic [3:0] alu_flags(input logic [15:0] x, input logic [15:0] y, input logic sub);
        logic [16:0] s;
        s = alu_sum(x, y, sub);
        return {^s[15:0], s[16], (s == 17'h0FFFF), (s == 17'd0)};
    endfunction

    logic [16:0] alu_s;
    assign alu_s   = alu_sum(alu_in1, alu_in2, alu_sub_en);
    assign alu_out = alu_status_out_en ? {12'b0, alu_flags(alu_in1, alu_in2, alu_sub_en)} : alu_s[15:0];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply_reset();
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_op    = 2'b00;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic check_idle_outputs(input string tag);
        checks++;
        if ({req_ready, rsp_valid, busy} !== 3'b100) begin
            failures++;
            $display("FAIL %s handshake got rdy/vld/busy=%b want 100", tag, {req_ready, rsp_valid, busy});
        end
        checks++;
        if ({rsp_data, rsp_flags} !== 20'd0) begin
            failures++;
            $display("FAIL %s rsp got data=%h flags=%b want 0", tag, rsp_data, rsp_flags);
        end
        checks++;
        if ({alu_in1, alu_in2, alu_sub_en, alu_status_out_en} !== 34'd0) begin
            failures++;
            $display("FAIL %s alu pins got in1=%h in2=%h sub=%b st=%b want 0", tag,
                     alu_in1, alu_in2, alu_sub_en, alu_status_out_en);
        end
    endtask

    // One full transaction: accept, latency, scoreboard compare, optional backpressure, handshake.
    task automatic do_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b, input int bp);
        logic [15:0]      e_data;
        logic [3:0]       e_flags;
        logic [WIDTH+3:0] got;
        int               lat;
        int               exp_lat;
        case (op)
            OP_ADD:  e_data = a + b;
            OP_SUB:  e_data = a - b;
            OP_MUL:  e_data = 16'(32'(a) * 32'(b));
            default: e_data = 16'd0;
        endcase
        e_flags = (op == OP_MUL) ? alu_flags(e_data, 16'd0, 1'b0) : alu_flags(a, b, op != OP_ADD);
        exp_lat = (op == OP_MUL) ? MUL_BITS + 1 : 2;
        exp_q.push_back({e_data, e_flags});

        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL accept_ready op=%0d got req_ready=%b want 1", op, req_ready);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_op    = 2'($urandom_range(0, 3));
        req_a     = 16'($urandom);
        req_b     = 16'($urandom);
        lat = 0;
        while (rsp_valid !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 1) begin
                checks++;
                if ({req_ready, busy} !== 2'b01) begin
                    failures++;
                    $display("FAIL busy_flags op=%0d got rdy/busy=%b want 01", op, {req_ready, busy});
                end
            end
        end
        checks++;
        if (lat !== exp_lat) begin
            failures++;
            $display("FAIL latency op=%0d got %0d want %0d", op, lat, exp_lat);
        end
        if (rsp_valid !== 1'b1) begin
            void'(exp_q.pop_front());
            return;
        end
        got = {rsp_data, rsp_flags};
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty got data=%h want queued entry", rsp_data);
        end else begin
            logic [WIDTH+3:0] exp_v;
            exp_v = exp_q.pop_front();
            if (got !== exp_v) begin
                failures++;
                $display("FAIL result op=%0d a=%h b=%h got data=%h flags=%b want data=%h flags=%b",
                         op, a, b, rsp_data, rsp_flags, exp_v[19:4], exp_v[3:0]);
            end
        end
        for (int i = 0; i < bp; i++) begin
            req_valid = 1'b1;
            @(posedge clk);
            #1;
            checks++;
            if ({rsp_valid, req_ready, rsp_data, rsp_flags} !== {2'b10, e_data, e_flags}) begin
                failures++;
                $display("FAIL backpressure cyc=%0d got vld=%b rdy=%b data=%h flags=%b want vld=1 rdy=0 data=%h flags=%b",
                         i, rsp_valid, req_ready, rsp_data, rsp_flags, e_data, e_flags);
            end
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        checks++;
        if ({rsp_valid, req_ready, busy} !== 3'b010) begin
            failures++;
            $display("FAIL rsp_release got vld/rdy/busy=%b want 010", {rsp_valid, req_ready, busy});
        end
    endtask

    task automatic test_reset();
        apply_reset();
        check_idle_outputs("reset");
    endtask

    task automatic test_directed();
        do_op(OP_ADD, 16'h1234, 16'h0001, 0);
        do_op(OP_SUB, 16'd5, 16'd5, 0);
        do_op(OP_SUB, 16'd0, 16'd1, 0);
        do_op(OP_MUL, 16'h0003, 16'h0005, 0);
        do_op(OP_MUL, 16'h0100, 16'h0100, 0);
        do_op(OP_CMP, 16'd7, 16'd7, 0);
        do_op(OP_ADD, 16'hFFFF, 16'h0001, 0);
        do_op(OP_MUL, 16'hFFFF, 16'hFFFF, 0);
        do_op(OP_CMP, 16'd3, 16'd9, 0);
    endtask

    task automatic test_backpressure();
        do_op(OP_ADD, 16'h00A0, 16'h000B, 5);
        do_op(OP_MUL, 16'h0012, 16'h0034, 3);
    endtask

    task automatic test_reset_mid_mul();
        req_valid = 1'b1;
        req_op    = OP_MUL;
        req_a     = 16'h0003;
        req_b     = 16'h0005;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (8) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_idle_outputs("mid_mul_reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        do_op(OP_ADD, 16'd2, 16'd3, 0);
    endtask

    task automatic test_back_to_back_random();
        for (int n = 0; n < 12; n++) begin
            do_op(2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom_range(0, 65535)),
                  $urandom_range(0, 3));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_mul();
        test_back_to_back_random();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover got %0d entries want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
